// File: rtl/mmio_button_input_if.sv
// IOBUS slice used by the button peripheral: CPU drives address/data/strobe,
// peripheral returns combinational read data.
interface mmio_button_input_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );
endinterface

// File: rtl/mmio_button_input.sv
// Memory-mapped button input: 2-flop sync, per-bit debounce, sticky W1C press
// events and a level interrupt for enabled events.
module mmio_button_input #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] BASE_AD         = 32'h11000060
) (
  input  logic               CLK,
  input  logic               RST,
  mmio_button_input_if.slave bus,
  input  logic [N_BTN-1:0]   BTN_RAW,
  output logic               INTR
);

  localparam int unsigned   CntW     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] AddrState = BASE_AD;
  localparam logic [31:0] AddrEvent = BASE_AD + 32'h4;
  localparam logic [31:0] AddrIrqEn = BASE_AD + 32'h8;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] prev_q;
  logic [N_BTN-1:0] event_q, event_d;
  logic [N_BTN-1:0] irq_en_q, irq_en_d;
  logic [CntW-1:0]  cnt_q [N_BTN];
  logic [CntW-1:0]  cnt_d [N_BTN];

  logic             wr_event, wr_irq_en;
  logic [N_BTN-1:0] wr_data;
  logic [N_BTN-1:0] rise;

  assign wr_event  = bus.IOBUS_WR && (bus.IOBUS_ADDR == AddrEvent);
  assign wr_irq_en = bus.IOBUS_WR && (bus.IOBUS_ADDR == AddrIrqEn);
  assign wr_data   = bus.IOBUS_OUT[N_BTN-1:0];
  assign rise      = stable_q & ~prev_q;

  // A level is accepted only after CntMax+1 consecutive mismatching cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    event_d = event_q;
    if (wr_event) begin
      event_d = event_q & ~wr_data;
    end
    event_d = event_d | rise;
  end

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_irq_en) begin
      irq_en_d = wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      event_q  <= '0;
      irq_en_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= BTN_RAW;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      event_q  <= event_d;
      irq_en_q <= irq_en_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.IOBUS_IN = 32'h0;
    if (bus.IOBUS_ADDR == AddrState) begin
      bus.IOBUS_IN = 32'(stable_q);
    end else if (bus.IOBUS_ADDR == AddrEvent) begin
      bus.IOBUS_IN = 32'(event_q);
    end else if (bus.IOBUS_ADDR == AddrIrqEn) begin
      bus.IOBUS_IN = 32'(irq_en_q);
    end
  end

  assign INTR = |(event_q & irq_en_q);

endmodule

// File: tb/tb_mmio_button_input.sv
// Directed bench for mmio_button_input with a short debounce window.
module tb_mmio_button_input;

  localparam int unsigned N_BTN = 5;
  localparam int unsigned DEB   = 4;
  localparam logic [31:0] BASE  = 32'h11000060;
  localparam logic [31:0] A_ST  = BASE;
  localparam logic [31:0] A_EV  = BASE + 32'h4;
  localparam logic [31:0] A_EN  = BASE + 32'h8;

  logic             CLK;
  logic             RST;
  logic [N_BTN-1:0] BTN_RAW;
  logic             INTR;

  int n_vec;
  int n_bad;

  mmio_button_input_if ifc ();

  mmio_button_input #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .BASE_AD         (BASE)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (ifc.slave),
    .BTN_RAW (BTN_RAW),
    .INTR    (INTR)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ifc.IOBUS_ADDR = a;
    #1;
    check_eq(tag, ifc.IOBUS_IN, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ifc.IOBUS_ADDR = a;
    ifc.IOBUS_OUT  = d;
    ifc.IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    ifc.IOBUS_WR   = 1'b0;
    ifc.IOBUS_OUT  = 32'h0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    RST = 1'b0;
    BTN_RAW = '0;
    ifc.IOBUS_ADDR = 32'h0;
    ifc.IOBUS_OUT  = 32'h0;
    ifc.IOBUS_WR   = 1'b0;

    // Reset then idle
    tick(3);
    RST = 1'b1;
    tick(1);
    check_rd("rst_state", A_ST, 32'h0);
    check_rd("rst_event", A_EV, 32'h0);
    check_rd("rst_irqen", A_EN, 32'h0);
    check_eq("rst_intr", 32'(INTR), 32'h0);

    // Clean press of bit 2, just after edge 0
    BTN_RAW = 5'h04;
    tick(5);
    check_rd("press_state_e5", A_ST, 32'h0);
    tick(1);
    check_rd("press_state_e6", A_ST, 32'h4);
    check_rd("press_event_e6", A_EV, 32'h0);
    tick(1);
    check_rd("press_event_e7", A_EV, 32'h4);
    check_eq("press_intr", 32'(INTR), 32'h0);
    BTN_RAW = 5'h00;
    tick(5);
    check_rd("rel_state_e5", A_ST, 32'h4);
    tick(1);
    check_rd("rel_state_e6", A_ST, 32'h0);
    tick(2);
    check_rd("rel_event", A_EV, 32'h4);
    bus_write(A_EV, 32'h4);
    check_rd("clr_event", A_EV, 32'h0);

    // Bounce: 3-cycle pulses never reach the debounce window
    for (int k = 0; k < 12; k++) begin
      BTN_RAW[0] = ((k / 3) % 2 == 0) && (k < 9);
      tick(1);
      check_rd("bounce_state", A_ST, 32'h0);
    end
    BTN_RAW = 5'h00;
    tick(8);
    check_rd("bounce_state_end", A_ST, 32'h0);
    check_rd("bounce_event_end", A_EV, 32'h0);
    check_eq("bounce_intr", 32'(INTR), 32'h0);

    // Interrupt and W1C
    bus_write(A_EN, 32'h1F);
    check_rd("irqen_rd", A_EN, 32'h1F);
    BTN_RAW = 5'h11;
    tick(7);
    check_rd("irq_event", A_EV, 32'h11);
    check_eq("irq_intr", 32'(INTR), 32'h1);
    bus_write(A_EV, 32'h01);
    check_rd("w1c1_event", A_EV, 32'h10);
    check_eq("w1c1_intr", 32'(INTR), 32'h1);
    bus_write(A_EV, 32'h10);
    check_rd("w1c2_event", A_EV, 32'h0);
    check_eq("w1c2_intr", 32'(INTR), 32'h0);
    BTN_RAW = 5'h00;
    tick(8);
    check_rd("rel2_state", A_ST, 32'h0);

    // Clear lands on the same edge bit 1's event sets
    BTN_RAW = 5'h02;
    tick(6);
    check_rd("same_pre_event", A_EV, 32'h0);
    bus_write(A_EV, 32'h2);
    check_rd("same_event", A_EV, 32'h2);

    // Reset mid-operation
    BTN_RAW = 5'h03;
    tick(7);
    check_rd("pre_rst_event", A_EV, 32'h3);
    check_eq("pre_rst_intr", 32'(INTR), 32'h1);
    BTN_RAW = 5'h0B;
    tick(4);
    RST = 1'b0;
    #1;
    check_eq("arst_intr", 32'(INTR), 32'h0);
    check_rd("arst_state", A_ST, 32'h0);
    check_rd("arst_event", A_EV, 32'h0);
    check_rd("arst_irqen", A_EN, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick(6);
    check_rd("post_state_e6", A_ST, 32'h0B);
    check_rd("post_event_e6", A_EV, 32'h0);
    tick(1);
    check_rd("post_event_e7", A_EV, 32'h0B);
    check_eq("post_intr", 32'(INTR), 32'h0);
    tick(3);
    check_rd("post_event_hold", A_EV, 32'h0B);

    // Address decode and read-only state
    check_rd("unmapped_6c", BASE + 32'hC, 32'h0);
    check_rd("unmapped_out", 32'h11000000, 32'h0);
    bus_write(A_ST, 32'h1F);
    check_rd("state_ro", A_ST, 32'h0B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_button_input.md
Name: mmio_button_input

Overview:
- Memory-mapped input peripheral on the OTTER IOBUS. It is the input-direction counterpart of the wrapper's LED/SSEG output registers.
- Synchronizes and debounces raw board buttons, exposes their debounced levels, and latches press events into a sticky, write-1-to-clear register.
- Raises an interrupt line toward the CPU for enabled events.
- Sits in the wrapper beside the switch read mux; its IOBUS_IN is ORed into the bus read data.

Parameters:
- N_BTN, 5, number of button inputs (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive CLK cycles a changed level must persist before it is accepted (10 ms at 50 MHz); minimum 1.
- BASE_AD, 32'h11000060, word address of register 0.

Ports:
- CLK  in  1  50 MHz system clock (the CPU clock).
- RST  in  1  asynchronous, active-low reset.
- IOBUS_ADDR  in  32  CPU bus address.
- IOBUS_OUT  in  32  CPU write data.
- IOBUS_WR  in  1  write strobe, valid for one CLK cycle.
- IOBUS_IN  out  32  read data; combinational from IOBUS_ADDR and internal registers.
- BTN_RAW  in  N_BTN  asynchronous raw button levels, 1 = pressed.
- INTR  out  1  interrupt request, level, active-high.

Behaviour:
- Register map (word offsets from BASE_AD):
  - +0x0 BTN_STATE: RO, debounced levels.
  - +0x4 BTN_EVENT: R/W1C, sticky press events.
  - +0x8 BTN_IRQ_EN: RW, per-button interrupt enable.
- Unused upper bits read 0.
- Unmapped addresses, including +0xC and any address outside the block, read 32'h0.
- Writes to BTN_STATE are ignored.
- Reset (RST=0, asynchronous):
  - synchronizers, stable levels, debounce counters, BTN_EVENT and BTN_IRQ_EN all clear to 0;
  - INTR=0.
- Reset asserted mid-debounce discards the count. After release, a button already held high is debounced afresh and produces one event.
- Synchronizer: 2 flops per bit; sync output lags BTN_RAW by 2 CLK edges.
- Debounce, per bit:
  - counter increments each cycle sync != stable;
  - counter resets to 0 on any cycle sync == stable;
  - when a mismatching cycle finds counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0;
  - counter width is clog2(DEBOUNCE_CYCLES)+1 and it never wraps.
- Bounce shorter than DEBOUNCE_CYCLES produces no stable change.
- Event detect:
  - a prev_stable register samples stable every cycle;
  - a rising edge (stable & ~prev_stable) sets the BTN_EVENT bit one edge after stable rises;
  - releases generate no event.
- W1C: a write to +0x4 clears each BTN_EVENT bit whose IOBUS_OUT bit is 1. If a set and a clear hit the same bit in the same cycle, set wins.
- BTN_IRQ_EN is written from IOBUS_OUT[N_BTN-1:0] on a write to +0x8; the new value is visible on the next edge.
- INTR = |(BTN_EVENT & BTN_IRQ_EN), combinational from registers only, so it is glitch-free relative to CLK. INTR stays high until all enabled pending bits are cleared or disabled.
- Latency from a BTN_RAW transition held stable from edge 0:
  - BTN_STATE updates at edge 2+DEBOUNCE_CYCLES;
  - BTN_EVENT and INTR update at edge 3+DEBOUNCE_CYCLES.
- Repeated presses before a clear leave the bit at 1; there is no counting or overflow.

Test Plan (N_BTN=5, DEBOUNCE_CYCLES=4, BASE_AD=32'h11000060):
- Reset then idle: RST=0 then 1, BTN_RAW=0 -> reads of 0x11000060/64/68 return 0, INTR=0.
- Clean press of bit 2 at edge 0, IRQ_EN=0 -> read 0x11000060 = 32'h4 from edge 6; 0x11000064 = 32'h4 from edge 7; INTR stays 0. Releasing bit 2 -> STATE returns to 0, EVENT stays 32'h4.
- Bounce: BTN_RAW[0] toggles 1,0,1,0 with 3-cycle pulses, then rests at 0 -> STATE, EVENT and INTR remain 0 throughout.
- Interrupt and W1C:
  - write 0x11000068 = 32'h1F, press bits 0 and 4 -> EVENT = 32'h11 and INTR=1;
  - write 0x11000064 = 32'h01 -> EVENT = 32'h10, INTR=1;
  - write 32'h10 -> EVENT=0, INTR=0.
- Simultaneous set and clear: time a W1C write of 32'h2 to land on the same edge that bit 1's event sets -> EVENT bit 1 = 1 afterwards.
- Reset mid-operation and address decode:
  - assert RST with EVENT = 32'h3 and a counter at 2 -> all registers 0 immediately, INTR drops asynchronously;
  - after release with a button held, one event appears at edge 7;
  - read 0x1100006C and 0x11000000 -> IOBUS_IN = 0.
